mc_sequencer: RTL and testbench

Multicycle control sequencer for the MIPS core. Steps each instruction through fetch, decode, execute, memory and writeback, and arbitrates the single shared memory port between instruction fetch and load/store. The combinational instruction decoder supplies the per-instruction intent (register write, memory write, writeback source, PC source); this block turns that intent into correctly timed one-cycle strobes. It also counts retired instructions and memory stall cycles.

---
 rtl/mc_seq_pkg.sv | 41 ++++
 rtl/mc_sat_counter.sv | 24 ++
 rtl/mc_sequencer.sv | 117 +++++++++++
 tb/tb_mc_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_seq_pkg.sv
// mc_sequencer shared types and encodings.
// Also used by the instruction decoder for its select constants.
package mc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5
  } state_e;

  localparam logic [1:0] PC_SEL_REG = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JMP = 2'd2;
  localparam logic [1:0] PC_SEL_INC = 2'd3;

  localparam logic [1:0] GP_SRC_ALU = 2'd0;
  localparam logic [1:0] GP_SRC_MEM = 2'd1;
  localparam logic [1:0] GP_SRC_SHF = 2'd2;
  localparam logic [1:0] GP_SRC_PC  = 2'd3;

  // An untaken branch falls through to the incremented PC.
  function automatic logic [1:0] eff_pc_sel(
    input logic [1:0] sel,
    input logic       taken
  );
    if (sel == PC_SEL_BR && !taken)
      return PC_SEL_INC;
    return sel;
  endfunction

  function automatic logic is_mem_op(
    input logic [1:0] gp_src,
    input logic       dm_we
  );
    return (gp_src == GP_SRC_MEM) || dm_we;
  endfunction

endpackage

// File: rtl/mc_sat_counter.sv
// Up-counter with increment enable.
// SAT=1 holds at all-ones, SAT=0 wraps.
module mc_sat_counter #(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && !(SAT && at_max))
      count <= count + W'(1);
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WB.
// Shares one memory port between fetch and load/store.
module mc_sequencer
  import mc_seq_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               mem_ack,
  input  logic               dec_gp_we,
  input  logic               dec_dm_we,
  input  logic [1:0]         dec_gp_mux_sel,
  input  logic [1:0]         dec_pc_mux_sel,
  input  logic               bce_taken,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic               ir_we,
  output logic               ab_we,
  output logic               mdr_we,
  output logic               gp_we,
  output logic               pc_we,
  output logic [1:0]         pc_sel,
  output logic [2:0]         state,
  output logic               busy,
  output logic [CNT_W-1:0]   retired,
  output logic [STALL_W-1:0] stall_cnt
);

  state_e cur, nxt;
  logic   is_load;

  assign is_load = (dec_gp_mux_sel == GP_SRC_MEM);
  assign state   = cur;
  assign busy    = (cur != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cur <= S_IDLE;
    else
      cur <= nxt;
  end

  always_comb begin
    nxt          = cur;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    ab_we        = 1'b0;
    mdr_we       = 1'b0;
    gp_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_INC;
    unique case (cur)
      S_IDLE: begin
        if (run)
          nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
        if (mem_ack)
          nxt = S_DECODE;
      end
      S_DECODE: begin
        ab_we = 1'b1;
        nxt   = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_mem_op(dec_gp_mux_sel, dec_dm_we))
          nxt = S_MEM;
        else
          nxt = S_WB;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_dm_we;
        mdr_we       = mem_ack && is_load;
        if (mem_ack)
          nxt = S_WB;
      end
      S_WB: begin
        pc_we  = 1'b1;
        gp_we  = dec_gp_we;
        pc_sel = eff_pc_sel(dec_pc_mux_sel, bce_taken);
        nxt    = run ? S_FETCH : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  mc_sat_counter #(
    .W   (CNT_W),
    .SAT (1'b0)
  ) u_retired (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cur == S_WB),
    .count (retired)
  );

  mc_sat_counter #(
    .W   (STALL_W),
    .SAT (1'b1)
  ) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_req && !mem_ack),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed scoreboard bench for mc_sequencer.
// Per-cycle expected outputs are queued and popped as the DUT responds.
module tb_mc_sequencer;

  localparam int CNT_W   = 32;
  localparam int STALL_W = 16;

  typedef struct packed {
    logic [2:0] st;
    logic       busy;
    logic       req;
    logic       we;
    logic       asel;
    logic       ir;
    logic       ab;
    logic       mdr;
    logic       gp;
    logic       pc;
    logic [1:0] psel;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               run;
  logic               mem_ack;
  logic               dec_gp_we;
  logic               dec_dm_we;
  logic [1:0]         dec_gp_mux_sel;
  logic [1:0]         dec_pc_mux_sel;
  logic               bce_taken;
  logic               mem_req;
  logic               mem_we;
  logic               mem_addr_sel;
  logic               ir_we;
  logic               ab_we;
  logic               mdr_we;
  logic               gp_we;
  logic               pc_we;
  logic [1:0]         pc_sel;
  logic [2:0]         state;
  logic               busy;
  logic [CNT_W-1:0]   retired;
  logic [STALL_W-1:0] stall_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   exp_retired = 0;
  int   exp_stall   = 0;

  mc_sequencer #(
    .CNT_W   (CNT_W),
    .STALL_W (STALL_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .mem_ack        (mem_ack),
    .dec_gp_we      (dec_gp_we),
    .dec_dm_we      (dec_dm_we),
    .dec_gp_mux_sel (dec_gp_mux_sel),
    .dec_pc_mux_sel (dec_pc_mux_sel),
    .bce_taken      (bce_taken),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr_sel   (mem_addr_sel),
    .ir_we          (ir_we),
    .ab_we          (ab_we),
    .mdr_we         (mdr_we),
    .gp_we          (gp_we),
    .pc_we          (pc_we),
    .pc_sel         (pc_sel),
    .state          (state),
    .busy           (busy),
    .retired        (retired),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [2:0] st,
    input logic req, input logic we, input logic asel,
    input logic ir, input logic ab, input logic mdr,
    input logic gp, input logic pc, input logic [1:0] psel
  );
    exp_t e;
    e.st = st; e.busy = (st != 3'd0);
    e.req = req; e.we = we; e.asel = asel;
    e.ir = ir; e.ab = ab; e.mdr = mdr;
    e.gp = gp; e.pc = pc; e.psel = psel;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.st = state; o.busy = busy;
    o.req = mem_req; o.we = mem_we; o.asel = mem_addr_sel;
    o.ir = ir_we; o.ab = ab_we; o.mdr = mdr_we;
    o.gp = gp_we; o.pc = pc_we; o.psel = pc_sel;
    return o;
  endfunction

  task automatic chk(input string tag, input exp_t got, input exp_t want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  task automatic chk_cnt(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  // Called at a negedge: drive ack, queue expectation, compare mid-phase.
  task automatic step(input string tag, input logic ack, input exp_t e);
    exp_t want;
    mem_ack = ack;
    sb.push_back(e);
    #2;
    want = sb.pop_front();
    chk(tag, observed(), want);
    @(negedge clk);
  endtask

  task automatic counters(input string tag);
    chk_cnt({tag, "_retired"}, int'(retired), exp_retired);
    chk_cnt({tag, "_stall"}, int'(stall_cnt), exp_stall);
  endtask

  task automatic instr(
    input string tag,
    input int fwait, input int mwait,
    input logic gpw, input logic dmw,
    input logic [1:0] gsel, input logic [1:0] psel,
    input logic taken, input logic run_after
  );
    logic       memop;
    logic       ld;
    logic [1:0] wb_psel;
    memop = (gsel == 2'd1) || dmw;
    ld    = (gsel == 2'd1);
    wb_psel = (psel == 2'd1 && !taken) ? 2'd3 : psel;
    dec_gp_we = gpw; dec_dm_we = dmw;
    dec_gp_mux_sel = gsel; dec_pc_mux_sel = psel;
    bce_taken = taken;
    for (int i = 0; i < fwait; i++) begin
      if (exp_stall < 65535) exp_stall++;
      step({tag, "_fwait"}, 1'b0, mk(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 2'd3));
    end
    step({tag, "_fetch"}, 1'b1, mk(3'd1, 1, 0, 0, 1, 0, 0, 0, 0, 2'd3));
    step({tag, "_decode"}, 1'b1, mk(3'd2, 0, 0, 0, 0, 1, 0, 0, 0, 2'd3));
    run = run_after;
    step({tag, "_exec"}, 1'b0, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3));
    if (memop) begin
      for (int i = 0; i < mwait; i++) begin
        if (exp_stall < 65535) exp_stall++;
        step({tag, "_mwait"}, 1'b0,
             mk(3'd4, 1, dmw, 1, 0, 0, 0, 0, 0, 2'd3));
      end
      step({tag, "_mem"}, 1'b1, mk(3'd4, 1, dmw, 1, 0, 0, ld, 0, 0, 2'd3));
    end
    step({tag, "_wb"}, 1'b0, mk(3'd5, 0, 0, 0, 0, 0, 0, gpw, 1, wb_psel));
    exp_retired++;
    counters(tag);
  endtask

  initial begin
    exp_t idle;
    idle = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3);
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0;
    dec_gp_we = 1'b0; dec_dm_we = 1'b0;
    dec_gp_mux_sel = 2'd0; dec_pc_mux_sel = 2'd3; bce_taken = 1'b0;
    @(negedge clk);
    step("reset", 1'b1, idle);
    counters("reset");
    rst_n = 1'b1;
    step("idle_norun", 1'b0, idle);
    run = 1'b1;
    step("idle_run", 1'b0, idle);

    instr("alu", 0, 0, 1, 0, 2'd0, 2'd3, 0, 1);
    instr("load", 2, 2, 1, 0, 2'd1, 2'd3, 0, 1);
    instr("store", 0, 0, 0, 1, 2'd0, 2'd3, 0, 1);
    instr("br_nt", 0, 0, 0, 0, 2'd0, 2'd1, 0, 1);
    instr("br_t", 0, 0, 0, 0, 2'd0, 2'd1, 1, 1);
    instr("jmp_stop", 0, 0, 0, 0, 2'd2, 2'd2, 0, 0);
    step("idle_after", 1'b1, idle);
    step("idle_hold", 1'b0, idle);

    run = 1'b1;
    step("idle_run2", 1'b0, idle);
    dec_gp_we = 1'b1; dec_dm_we = 1'b0;
    dec_gp_mux_sel = 2'd1; dec_pc_mux_sel = 2'd3;
    step("rst_fetch", 1'b1, mk(3'd1, 1, 0, 0, 1, 0, 0, 0, 0, 2'd3));
    step("rst_decode", 1'b0, mk(3'd2, 0, 0, 0, 0, 1, 0, 0, 0, 2'd3));
    step("rst_exec", 1'b0, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3));
    step("rst_mwait", 1'b0, mk(3'd4, 1, 0, 1, 0, 0, 0, 0, 0, 2'd3));
    mem_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_retired = 0; exp_stall = 0;
    chk("rst_async", observed(), idle);
    counters("rst_async");
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1;
    step("restart_idle", 1'b0, idle);
    instr("restart", 1, 0, 1, 0, 2'd0, 2'd3, 0, 1);
    instr("sat", 65540, 0, 1, 0, 2'd2, 2'd0, 0, 0);
    step("sat_idle", 1'b0, idle);
    chk_cnt("sat_max", int'(stall_cnt), 65535);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
